// File: rtl/usb_rx_pkg.sv
// rtl/usb_rx_pkg.sv - shared types, constants and PID helper for the USB receive path
package usb_rx_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SYNC  = 2'd1,
      DATA  = 2'd2,
      ERROR = 2'd3
   } rx_state_e;

   typedef enum logic [2:0] {
      ERR_NONE     = 3'd0,
      ERR_STUFF    = 3'd1,
      ERR_ALIGN    = 3'd2,
      ERR_OVERFLOW = 3'd3,
      ERR_TIMEOUT  = 3'd4,
      ERR_PID      = 3'd5
   } rx_err_e;

   // SYNC as it arrives LSB-first: a run of zeros closed by a single one.
   localparam logic [7:0] SYNC_PATTERN = 8'h80;

   localparam int RX_SYNC_MIN_ZEROS = 5;
   localparam int RX_MAX_BYTES      = 1027;
   localparam int RX_BIT_TIMEOUT    = 96;
   localparam int RX_RESET_CLKS     = 120;

   // A PID byte carries its own check nibble: the upper nibble is the complement of the lower.
   function automatic logic pid_ok(input logic [7:0] pid);
      return pid[3:0] == ~pid[7:4];
   endfunction

endpackage

// File: rtl/usb_rx_packet_ctrl_if.sv
// rtl/usb_rx_packet_ctrl_if.sv - bit-level input and byte/status output bundle of the receive sequencer
interface usb_rx_packet_ctrl_if;

   logic       rx_bit;
   logic       rx_bit_valid;
   logic       rx_stuff_err;
   logic       rx_se0;
   logic       rx_eop;
   logic [7:0] rx_data;
   logic       rx_data_valid;
   logic       rx_sop;
   logic       rx_pkt_end;
   logic       rx_err;
   logic [2:0] rx_err_code;
   logic       rx_active;
   logic       bus_reset;

   // Line side: the decoder front end feeding bits and consuming packet status.
   modport master (
      output rx_bit, rx_bit_valid, rx_stuff_err, rx_se0, rx_eop,
      input  rx_data, rx_data_valid, rx_sop, rx_pkt_end, rx_err, rx_err_code, rx_active, bus_reset
   );

   // Sequencer side.
   modport slave (
      input  rx_bit, rx_bit_valid, rx_stuff_err, rx_se0, rx_eop,
      output rx_data, rx_data_valid, rx_sop, rx_pkt_end, rx_err, rx_err_code, rx_active, bus_reset
   );

endinterface

// File: rtl/usb_se0_reset_timer.sv
// rtl/usb_se0_reset_timer.sv - bus reset detection from a sustained SE0 level
module usb_se0_reset_timer #(
   parameter int RESET_CLKS = 120
) (
   input  logic clk,
   input  logic rst_n,
   input  logic rx_se0,
   output logic bus_reset
);

   localparam int               CNT_W   = $clog2(RESET_CLKS + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RESET_CLKS);

   logic [CNT_W-1:0] se0_cnt;

   // Count consecutive SE0 cycles, holding at the threshold; any non-SE0 cycle restarts the count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         se0_cnt <= '0;
      end else if (!rx_se0) begin
         se0_cnt <= '0;
      end else if (se0_cnt != CNT_MAX) begin
         se0_cnt <= se0_cnt + 1'b1;
      end
   end

   assign bus_reset = (se0_cnt == CNT_MAX);

endmodule

// File: rtl/usb_rx_packet_ctrl.sv
// rtl/usb_rx_packet_ctrl.sv - USB receive packet sequencer (SYNC hunt, byte framing, close, errors); PID check under RX_PID_CHECK_EN
module usb_rx_packet_ctrl
   import usb_rx_pkg::*;
#(
   parameter int SYNC_MIN_ZEROS = RX_SYNC_MIN_ZEROS,
   parameter int MAX_BYTES      = RX_MAX_BYTES,
   parameter int BIT_TIMEOUT    = RX_BIT_TIMEOUT,
   parameter int RESET_CLKS     = RX_RESET_CLKS
) (
   input logic                 clk,
   input logic                 rst_n,
   usb_rx_packet_ctrl_if.slave rx
);

   localparam int                BYTE_W     = $clog2(MAX_BYTES + 1);
   localparam int                IDLE_W     = $clog2(BIT_TIMEOUT + 1);
   localparam logic [BYTE_W-1:0] BYTE_LIMIT = BYTE_W'(MAX_BYTES);
   localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(BIT_TIMEOUT);
   localparam logic [2:0]        ZERO_MIN   = 3'(SYNC_MIN_ZEROS);

   rx_state_e         state;
   logic [2:0]        zero_cnt;
   logic [2:0]        bit_cnt;
   logic [7:0]        shift_q;
   logic [BYTE_W-1:0] byte_cnt;
   logic [IDLE_W-1:0] idle_cnt;
   logic              eop_pend;
   logic              bus_reset;

   logic [7:0]        data_q;
   logic              data_valid_q;
   logic              sop_q;
   logic              pkt_end_q;
   logic              err_q;
   logic              active_q;
   rx_err_e           err_code_q;

   logic [7:0]        next_byte;
   logic              byte_done;
   logic              close_now;
   logic              pid_bad;
   rx_err_e           err_cause;

   usb_se0_reset_timer #(
      .RESET_CLKS (RESET_CLKS)
   ) u_se0_timer (
      .clk       (clk),
      .rst_n     (rst_n),
      .rx_se0    (rx.rx_se0),
      .bus_reset (bus_reset)
   );

   // Bits arrive LSB-first, so each new bit enters at the top and the byte shifts down.
   assign next_byte = {rx.rx_bit, shift_q[7:1]};
   assign byte_done = rx.rx_bit_valid && (bit_cnt == 3'd7);
   // An EOP that lands on the 8th bit is deferred one cycle so the byte goes out first.
   assign close_now = (rx.rx_eop || eop_pend) && !byte_done;

`ifdef RX_PID_CHECK_EN
   assign pid_bad = (byte_cnt == '0) && !pid_ok(next_byte);
`else
   assign pid_bad = 1'b0;
`endif

   // Error cause for this cycle while in DATA; stuff error outranks EOP, EOP outranks byte events.
   always_comb begin
      err_cause = ERR_NONE;
      if (state == DATA) begin
         if (rx.rx_stuff_err) begin
            err_cause = ERR_STUFF;
         end else if (!close_now) begin
            if (byte_done) begin
               if (byte_cnt == BYTE_LIMIT) begin
                  err_cause = ERR_OVERFLOW;
               end else if (pid_bad) begin
                  err_cause = ERR_PID;
               end
            end else if (!rx.rx_bit_valid && (idle_cnt == IDLE_LIMIT)) begin
               err_cause = ERR_TIMEOUT;
            end
         end
      end
   end

   // Bit-gap watchdog: runs only inside a packet and restarts on every received bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idle_cnt <= '0;
      end else if ((state != DATA) || rx.rx_bit_valid) begin
         idle_cnt <= '0;
      end else if (idle_cnt != IDLE_LIMIT) begin
         idle_cnt <= idle_cnt + 1'b1;
      end
   end

   // Packet sequencer with registered strobes; bus reset overrides everything silently.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         zero_cnt     <= '0;
         bit_cnt      <= '0;
         shift_q      <= '0;
         byte_cnt     <= '0;
         eop_pend     <= 1'b0;
         data_q       <= 8'h00;
         data_valid_q <= 1'b0;
         sop_q        <= 1'b0;
         pkt_end_q    <= 1'b0;
         err_q        <= 1'b0;
         active_q     <= 1'b0;
         err_code_q   <= ERR_NONE;
      end else begin
         data_valid_q <= 1'b0;
         sop_q        <= 1'b0;
         pkt_end_q    <= 1'b0;
         err_q        <= 1'b0;
         err_code_q   <= ERR_NONE;
         eop_pend     <= 1'b0;

         if (bus_reset) begin
            state    <= IDLE;
            active_q <= 1'b0;
            zero_cnt <= '0;
            bit_cnt  <= '0;
            byte_cnt <= '0;
         end else begin
            case (state)
               IDLE: begin
                  if (rx.rx_bit_valid && (rx.rx_bit == SYNC_PATTERN[0])) begin
                     state    <= SYNC;
                     zero_cnt <= 3'd1;
                  end
               end

               SYNC: begin
                  if (rx.rx_eop || rx.rx_stuff_err) begin
                     state <= IDLE;
                  end else if (rx.rx_bit_valid) begin
                     if (rx.rx_bit == SYNC_PATTERN[0]) begin
                        if (zero_cnt != 3'd7) begin
                           zero_cnt <= zero_cnt + 3'd1;
                        end
                     end else if ((rx.rx_bit == SYNC_PATTERN[7]) && (zero_cnt >= ZERO_MIN)) begin
                        state    <= DATA;
                        sop_q    <= 1'b1;
                        active_q <= 1'b1;
                        bit_cnt  <= '0;
                        byte_cnt <= '0;
                     end else begin
                        state <= IDLE;
                     end
                  end
               end

               DATA: begin
                  if (rx.rx_bit_valid && !rx.rx_stuff_err && !close_now) begin
                     shift_q <= next_byte;
                     bit_cnt <= bit_cnt + 3'd1;
                  end
                  if (byte_done && !rx.rx_stuff_err && (byte_cnt != BYTE_LIMIT)) begin
                     data_q       <= next_byte;
                     data_valid_q <= 1'b1;
                     byte_cnt     <= byte_cnt + 1'b1;
                  end
                  if ((err_cause != ERR_NONE) || byte_done) begin
                     eop_pend <= eop_pend || rx.rx_eop;
                  end
                  if (err_cause != ERR_NONE) begin
                     state      <= ERROR;
                     pkt_end_q  <= 1'b1;
                     err_q      <= 1'b1;
                     err_code_q <= err_cause;
                     active_q   <= 1'b0;
                  end else if (close_now) begin
                     state     <= IDLE;
                     pkt_end_q <= 1'b1;
                     active_q  <= 1'b0;
                     if ((bit_cnt != 3'd0) || (byte_cnt == '0)) begin
                        err_q      <= 1'b1;
                        err_code_q <= ERR_ALIGN;
                     end
                  end
               end

               ERROR: begin
                  if (rx.rx_eop || eop_pend) begin
                     state <= IDLE;
                  end
               end

               default: state <= IDLE;
            endcase
         end
      end
   end

   assign rx.rx_data       = data_q;
   assign rx.rx_data_valid = data_valid_q;
   assign rx.rx_sop        = sop_q;
   assign rx.rx_pkt_end    = pkt_end_q;
   assign rx.rx_err        = err_q;
   assign rx.rx_err_code   = err_code_q;
   assign rx.rx_active     = active_q;
   assign rx.bus_reset     = bus_reset;

endmodule

// File: tb/tb_usb_rx_packet_ctrl.sv
// tb/tb_usb_rx_packet_ctrl.sv - randomized packet bench for usb_rx_packet_ctrl against a packet-level model
module tb_usb_rx_packet_ctrl;

   localparam int MIN_Z    = 5;
   localparam int MAXB     = 1027;
   localparam int TMO      = 96;
   localparam int RST_CLKS = 120;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   tests_run    = 0;
   int   tests_failed = 0;
   int   cyc = 0;

   usb_rx_packet_ctrl_if rx_if ();

   usb_rx_packet_ctrl #(
      .SYNC_MIN_ZEROS (MIN_Z),
      .MAX_BYTES      (MAXB),
      .BIT_TIMEOUT    (TMO),
      .RESET_CLKS     (RST_CLKS)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .rx    (rx_if)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   logic [7:0] tx_q[$];
   logic [7:0] got_q[$];
   int         sop_cnt, end_cnt, err_cnt, strobe_bad;
   int         end_cyc, data_cyc, eop_cyc, last_bit_cyc;
   logic [2:0] last_code;

   // Observe the output strobes between clock edges.
   always @(negedge clk) begin
      if (rst_n) begin
         if (rx_if.rx_data_valid) begin
            got_q.push_back(rx_if.rx_data);
            data_cyc = cyc;
            if (!rx_if.rx_active && !rx_if.rx_pkt_end) strobe_bad++;
         end
         if (rx_if.rx_sop) begin
            sop_cnt++;
            if (!rx_if.rx_active) strobe_bad++;
         end
         if (rx_if.rx_err && !rx_if.rx_pkt_end) strobe_bad++;
         if (rx_if.rx_pkt_end) begin
            end_cnt++;
            end_cyc = cyc;
            if (rx_if.rx_err) begin
               err_cnt++;
               last_code = rx_if.rx_err_code;
            end
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   function automatic bit model_pid_bad(input logic [7:0] b);
`ifdef RX_PID_CHECK_EN
      int lo, hi;
      lo = int'(b) % 16;
      hi = int'(b) / 16;
      return lo != (15 - hi);
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [7:0] good_pid_byte();
      int lo;
      lo = $urandom_range(15, 0);
      return 8'((15 - lo) * 16 + lo);
   endfunction

   task automatic clear_mon();
      got_q.delete();
      sop_cnt = 0; end_cnt = 0; err_cnt = 0; strobe_bad = 0;
      end_cyc = -1; data_cyc = -1; last_code = 3'd0;
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_bit(input logic b, input logic with_eop);
      rx_if.rx_bit       = b;
      rx_if.rx_bit_valid = 1'b1;
      rx_if.rx_eop       = with_eop;
      last_bit_cyc       = cyc + 1;
      tick(1);
      rx_if.rx_bit_valid = 1'b0;
      rx_if.rx_eop       = 1'b0;
   endtask

   task automatic pulse_eop();
      eop_cyc      = cyc + 1;
      rx_if.rx_eop = 1'b1;
      tick(1);
      rx_if.rx_eop = 1'b0;
   endtask

   task automatic pulse_stuff();
      rx_if.rx_stuff_err = 1'b1;
      tick(1);
      rx_if.rx_stuff_err = 1'b0;
   endtask

   // term: 0 eop after bits, 1 eop with last data bit, 2 stuff error then eop, 3 silence (timeout) then eop
   task automatic run_pkt(input string name, input int zeros, input int extra, input int term, input int max_gap);
      int         nb, exp_n, exp_code, mism, byte_bit_cyc;
      logic [7:0] b;
      nb = tx_q.size();
      exp_n = nb;
      exp_code = 0;
      byte_bit_cyc = -1;
      if (nb >= 1 && model_pid_bad(tx_q[0])) begin
         exp_n = 1; exp_code = 5;
      end else if (nb > MAXB) begin
         exp_n = MAXB; exp_code = 3;
      end else begin
         case (term)
            0: exp_code = (extra != 0 || nb == 0) ? 2 : 0;
            1: exp_code = 0;
            2: exp_code = 1;
            default: exp_code = 4;
         endcase
      end

      clear_mon();
      for (int i = 0; i < zeros; i++) begin
         send_bit(1'b0, 1'b0);
         tick($urandom_range(max_gap, 0));
      end
      send_bit(1'b1, 1'b0);
      tick($urandom_range(max_gap, 0));
      for (int j = 0; j < nb; j++) begin
         b = tx_q[j];
         for (int i = 0; i < 8; i++) begin
            send_bit(b[i], (term == 1) && (j == nb - 1) && (i == 7));
            if (i == 7) byte_bit_cyc = last_bit_cyc;
            tick($urandom_range(max_gap, 0));
         end
      end
      for (int i = 0; i < extra; i++) begin
         send_bit(1'($urandom_range(1, 0)), 1'b0);
         tick($urandom_range(max_gap, 0));
      end
      case (term)
         0: pulse_eop();
         1: eop_cyc = last_bit_cyc;
         2: begin
            pulse_stuff();
            for (int i = 0; i < 5; i++) send_bit(1'($urandom_range(1, 0)), 1'b0);
            pulse_eop();
         end
         default: begin
            tick(TMO + 6);
            pulse_eop();
         end
      endcase
      tick(4);

      mism = 0;
      for (int j = 0; j < exp_n && j < got_q.size(); j++) begin
         if (got_q[j] !== tx_q[j]) mism++;
      end
      check({name, " sop"}, sop_cnt, 1);
      check({name, " nbytes"}, got_q.size(), exp_n);
      check({name, " bytes"}, mism, 0);
      check({name, " pkt_end"}, end_cnt, 1);
      check({name, " err"}, err_cnt, (exp_code != 0) ? 1 : 0);
      if (exp_code != 0) check({name, " err_code"}, last_code, exp_code);
      check({name, " strobes"}, strobe_bad, 0);
      check({name, " active_low"}, rx_if.rx_active, 0);
      if (term == 0 && (exp_code == 0 || exp_code == 2)) check({name, " eop_lat"}, end_cyc, eop_cyc);
      if (term == 1 && exp_code == 0) check({name, " close_after_byte"}, end_cyc, eop_cyc + 1);
      if (term == 3 && exp_code == 4)
         check({name, " tmo_lat"}, (end_cyc - last_bit_cyc >= TMO) && (end_cyc - last_bit_cyc <= TMO + 2), 1);
      if (exp_n >= 1 && exp_code != 3 && exp_code != 5) check({name, " data_lat"}, data_cyc, byte_bit_cyc);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int nb, term, extra;
      rx_if.rx_bit = 1'b0; rx_if.rx_bit_valid = 1'b0; rx_if.rx_stuff_err = 1'b0;
      rx_if.rx_se0 = 1'b0; rx_if.rx_eop = 1'b0;
      clear_mon();
      #3;
      check("reset_state", {rx_if.rx_data, rx_if.rx_data_valid, rx_if.rx_sop, rx_if.rx_pkt_end, rx_if.rx_err,
                            rx_if.rx_err_code, rx_if.rx_active, rx_if.bus_reset}, 0);
      tick(2);
      rst_n = 1'b1;
      tick(2);
      check("after_release", {rx_if.rx_data, rx_if.rx_data_valid, rx_if.rx_pkt_end, rx_if.rx_active}, 0);

      tx_q = {8'hA5, 8'h3C};          run_pkt("basic", MIN_Z, 0, 0, 2);
      tx_q = {8'h96};                 run_pkt("align12", 7, 4, 0, 1);
      tx_q = {};                      run_pkt("empty", 6, 0, 0, 0);
      tx_q = {8'hE1};                 run_pkt("stuff", 6, 0, 2, 1);
      tx_q = {};                      run_pkt("timeout", 7, 0, 3, 0);
      tx_q = {8'h5A, 8'h0F};          run_pkt("eop_on_bit8", 6, 0, 1, 1);
      tx_q = {8'h2D, 8'h55};          run_pkt("pid_2d", 6, 0, 0, 0);
      tx_q = {8'h2C, 8'h55};          run_pkt("pid_2c", 6, 0, 0, 0);

      // Short SYNC: one zero below the threshold must not open a packet.
      clear_mon();
      for (int i = 0; i < MIN_Z - 1; i++) send_bit(1'b0, 1'b0);
      send_bit(1'b1, 1'b0);
      for (int i = 0; i < 8; i++) send_bit(1'b1, 1'b0);
      tick(4);
      check("short_sync sop", sop_cnt, 0);
      check("short_sync active", rx_if.rx_active, 0);
      check("short_sync data", got_q.size(), 0);

      // Overflow: one byte beyond the packet limit.
      tx_q = {8'hC3};
      for (int i = 0; i < MAXB; i++) tx_q.push_back(8'($urandom));
      run_pkt("overflow", 6, 0, 0, 0);

      // SE0 just short of and exactly at the bus reset threshold.
      rx_if.rx_se0 = 1'b1;
      tick(RST_CLKS - 1);
      check("se0_119 bus_reset", rx_if.bus_reset, 0);
      rx_if.rx_se0 = 1'b0;
      tick(1);
      rx_if.rx_se0 = 1'b1;
      tick(RST_CLKS - 1);
      check("se0_restart bus_reset", rx_if.bus_reset, 0);
      tick(1);
      check("se0_120 bus_reset", rx_if.bus_reset, 1);
      tick(3);
      check("se0_hold bus_reset", rx_if.bus_reset, 1);
      rx_if.rx_se0 = 1'b0;
      tick(1);
      check("se0_release bus_reset", rx_if.bus_reset, 0);

      // Bus reset during a packet: bit silence times out first, then reset forces the sequencer idle.
      clear_mon();
      for (int i = 0; i < 6; i++) send_bit(1'b0, 1'b0);
      send_bit(1'b1, 1'b0);
      for (int i = 0; i < 8; i++) send_bit(1'(8'hA5 >> i), 1'b0);
      rx_if.rx_se0 = 1'b1;
      tick(RST_CLKS);
      check("busrst bus_reset", rx_if.bus_reset, 1);
      check("busrst active", rx_if.rx_active, 0);
      check("busrst pkt_end", end_cnt, 1);
      check("busrst code", last_code, 4);
      rx_if.rx_se0 = 1'b0;
      tick(1);
      tx_q = {8'h3C, 8'h99};          run_pkt("after_busrst", 6, 0, 0, 1);

      // Asynchronous reset in the middle of a packet.
      clear_mon();
      for (int i = 0; i < 6; i++) send_bit(1'b0, 1'b0);
      send_bit(1'b1, 1'b0);
      for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
      check("mid_rst active_before", rx_if.rx_active, 1);
      #2 rst_n = 1'b0;
      #1 check("mid_rst outputs", {rx_if.rx_data_valid, rx_if.rx_pkt_end, rx_if.rx_err, rx_if.rx_active}, 0);
      tick(2);
      rst_n = 1'b1;
      clear_mon();
      tick(6);
      check("mid_rst no_strobes", end_cnt + sop_cnt + got_q.size(), 0);

      // Randomized packets.
      for (int p = 0; p < 30; p++) begin
         nb = $urandom_range(6, 0);
         tx_q = {};
         for (int j = 0; j < nb; j++) tx_q.push_back(8'($urandom));
         if (nb > 0 && $urandom_range(1, 0) == 1) tx_q[0] = good_pid_byte();
         term  = $urandom_range(3, 0);
         extra = ($urandom_range(2, 0) == 0) ? $urandom_range(7, 1) : 0;
         if (term == 1) extra = 0;
         if (term == 1 && nb == 0) term = 0;
         run_pkt($sformatf("rand%0d", p), $urandom_range(8, MIN_Z), extra, term, 3);
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
